// File: rtl/timex_host_link.sv
// -----------------------------------------------------------------------------
// timex_host_link
//   Host end of the Timex FDD link. A host data write is pushed to the FDD
//   board with a nEXT_WR cycle; a fetch command runs a nEXT_RD cycle and holds
//   the returned byte for the host. One register pair: data (a0=0) and
//   status/command (a0=1).
//
// Ports
//   clk_16mhz   in     system clock
//   nRESET      in     asynchronous active-low reset
//   host_sel    in     host I/O decode for this block, active high
//   host_a0     in     0 = data register, 1 = status/command register
//   nRD, nWR    in     host strobes, active low, asynchronous to clk_16mhz
//   host_din    in  8  host write data
//   host_dout   out 8  host read data (rx byte or status)
//   host_doe    out    host_dout enable (host_sel & ~nRD)
//   ext_data    io  8  link data bus, driven only during a write cycle
//   nEXT_WR     out    link write strobe, active low
//   nEXT_RD     out    link read strobe, active low
//   nHOST_INT   out    host interrupt, active low
//
// Status byte: {tx_busy, rx_valid, rx_busy, ovr, irq, 3'b000}
// Command byte: bit0 fetch, bit1 clear ovr, bits 7:6 irq mask
//
// Build option LINK_IRQ_EN: when defined, adds the irq mask, the tx_done
// flag and a registered nHOST_INT; otherwise nHOST_INT is tied high and the
// status irq bit reads 0.
// -----------------------------------------------------------------------------
module timex_host_link #(
   parameter int SETUP_CYCLES  = 2,
   parameter int STROBE_CYCLES = 8,
   parameter int HOLD_CYCLES   = 2
) (
   input  logic       clk_16mhz,
   input  logic       nRESET,
   input  logic       host_sel,
   input  logic       host_a0,
   input  logic       nRD,
   input  logic       nWR,
   input  logic [7:0] host_din,
   output logic [7:0] host_dout,
   output logic       host_doe,
   inout  wire  [7:0] ext_data,
   output logic       nEXT_WR,
   output logic       nEXT_RD,
   output logic       nHOST_INT
);

   localparam int MAX_SH  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
   localparam int MAX_CYC = (STROBE_CYCLES > MAX_SH) ? STROBE_CYCLES : MAX_SH;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WR_SETUP  = 3'd1,
      S_WR_STROBE = 3'd2,
      S_WR_HOLD   = 3'd3,
      S_RD_STROBE = 3'd4,
      S_RD_HOLD   = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // bit0 is the raw request, bit1 the synchronized level, bit2 its delayed copy
   logic [2:0] wr_sync_q;
   logic [2:0] rd_sync_q;

   logic [7:0] tx_reg_q;
   logic       tx_pend_q;
   logic [7:0] rx_reg_q;
   logic       rx_valid_q;
   logic       rx_req_q;
   logic       ovr_q;
   logic       rd_a0_q;
   logic [7:0] host_dout_q;
   logic       nwr_q, nrd_q, oe_q;
   logic       nwr_d, nrd_d, oe_d;

   logic wr_fire_s, rd_start_s, rd_end_s;
   logic data_wr_s, cmd_wr_s, wr_cycle_s, rd_cycle_s;
   logic tx_accept_s, tx_drop_s;
   logic strobe_enter_s, wr_done_s, rx_cap_s;
   logic tx_busy_s, rx_busy_s, irq_s;
   logic [7:0] status_s;
   logic unused_s;

   assign wr_fire_s  = wr_sync_q[1] & ~wr_sync_q[2];
   assign rd_start_s = rd_sync_q[1] & ~rd_sync_q[2];
   assign rd_end_s   = ~rd_sync_q[1] & rd_sync_q[2];

   assign data_wr_s  = wr_fire_s & ~host_a0;
   assign cmd_wr_s   = wr_fire_s & host_a0;
   assign wr_cycle_s = (state_q == S_WR_SETUP) || (state_q == S_WR_STROBE) || (state_q == S_WR_HOLD);
   assign rd_cycle_s = (state_q == S_RD_STROBE) || (state_q == S_RD_HOLD);

   // A byte is only taken when nothing is queued and no write cycle is running
   assign tx_accept_s = data_wr_s & ~tx_pend_q & ~wr_cycle_s;
   assign tx_drop_s   = data_wr_s & ~tx_accept_s;

   assign strobe_enter_s = (state_d == S_WR_STROBE) && (state_q != S_WR_STROBE);
   assign wr_done_s      = ((state_q == S_WR_STROBE) || (state_q == S_WR_HOLD)) &&
                           !((state_d == S_WR_STROBE) || (state_d == S_WR_HOLD));
   assign rx_cap_s       = (state_q == S_RD_STROBE) && (cnt_q == CNT_W'(STROBE_CYCLES - 1));

   assign tx_busy_s = tx_pend_q | wr_cycle_s;
   assign rx_busy_s = rx_req_q | rd_cycle_s;
   assign status_s  = {tx_busy_s, rx_valid_q, rx_busy_s, ovr_q, irq_s, 3'b000};

   assign host_doe  = host_sel & ~nRD;
   assign host_dout = host_dout_q;
   assign nEXT_WR   = nwr_q;
   assign nEXT_RD   = nrd_q;
   assign ext_data  = oe_q ? tx_reg_q : 8'hzz;

   // Host strobe synchronizers
   always_ff @(posedge clk_16mhz or negedge nRESET) begin
      if (!nRESET) begin
         wr_sync_q <= 3'b000;
         rd_sync_q <= 3'b000;
      end else begin
         wr_sync_q <= {wr_sync_q[1:0], host_sel & ~nWR};
         rd_sync_q <= {rd_sync_q[1:0], host_sel & ~nRD};
      end
   end

   // FSM state and phase counter register
   always_ff @(posedge clk_16mhz or negedge nRESET) begin
      if (!nRESET) begin
         state_q <= S_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state; a write always wins over a pending fetch
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      case (state_q)
         S_IDLE: begin
            cnt_d = {CNT_W{1'b0}};
            if (tx_pend_q || tx_accept_s) begin
               state_d = (SETUP_CYCLES == 0) ? S_WR_STROBE : S_WR_SETUP;
            end else if (rx_req_q) begin
               state_d = S_RD_STROBE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WR_SETUP: begin
            if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
               state_d = S_WR_STROBE;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               state_d = S_WR_SETUP;
            end
         end
         S_WR_STROBE: begin
            if (cnt_q == CNT_W'(STROBE_CYCLES - 1)) begin
               cnt_d = {CNT_W{1'b0}};
               if (HOLD_CYCLES == 0) begin
                  state_d = rx_req_q ? S_RD_STROBE : S_IDLE;
               end else begin
                  state_d = S_WR_HOLD;
               end
            end else begin
               state_d = S_WR_STROBE;
            end
         end
         S_WR_HOLD: begin
            // a fetch queued behind the write starts without an idle clock
            if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = rx_req_q ? S_RD_STROBE : S_IDLE;
            end else begin
               state_d = S_WR_HOLD;
            end
         end
         S_RD_STROBE: begin
            if (cnt_q == CNT_W'(STROBE_CYCLES - 1)) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = (HOLD_CYCLES == 0) ? S_IDLE : S_RD_HOLD;
            end else begin
               state_d = S_RD_STROBE;
            end
         end
         S_RD_HOLD: begin
            if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = S_IDLE;
            end else begin
               state_d = S_RD_HOLD;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // FSM outputs decoded from the next state so the registered pins line up with it
   always_comb begin
      nwr_d = 1'b1;
      nrd_d = 1'b1;
      oe_d  = 1'b0;
      case (state_d)
         S_WR_SETUP:  oe_d  = 1'b1;
         S_WR_STROBE: begin
            oe_d  = 1'b1;
            nwr_d = 1'b0;
         end
         S_WR_HOLD:   oe_d  = 1'b1;
         S_RD_STROBE: nrd_d = 1'b0;
         default: begin
            nwr_d = 1'b1;
            nrd_d = 1'b1;
            oe_d  = 1'b0;
         end
      endcase
   end

   // Link pin registers
   always_ff @(posedge clk_16mhz or negedge nRESET) begin
      if (!nRESET) begin
         nwr_q <= 1'b1;
         nrd_q <= 1'b1;
         oe_q  <= 1'b0;
      end else begin
         nwr_q <= nwr_d;
         nrd_q <= nrd_d;
         oe_q  <= oe_d;
      end
   end

   // Host-visible registers and flags
   always_ff @(posedge clk_16mhz or negedge nRESET) begin
      if (!nRESET) begin
         tx_reg_q    <= 8'h00;
         tx_pend_q   <= 1'b0;
         rx_reg_q    <= 8'h00;
         rx_valid_q  <= 1'b0;
         rx_req_q    <= 1'b0;
         ovr_q       <= 1'b0;
         rd_a0_q     <= 1'b0;
         host_dout_q <= 8'h00;
      end else begin
         if (tx_accept_s) begin
            tx_reg_q <= host_din;
         end
         // clear on strobe entry overrides the set so a zero-setup build still empties
         if (strobe_enter_s) begin
            tx_pend_q <= 1'b0;
         end else if (tx_accept_s) begin
            tx_pend_q <= 1'b1;
         end
         if (rx_cap_s) begin
            rx_reg_q <= ext_data;
         end
         if (rx_cap_s) begin
            rx_valid_q <= 1'b1;
         end else if (rd_end_s && !rd_a0_q) begin
            rx_valid_q <= 1'b0;
         end
         if (cmd_wr_s && host_din[0]) begin
            rx_req_q <= 1'b1;
         end else if (rx_cap_s) begin
            rx_req_q <= 1'b0;
         end
         if ((rx_cap_s && rx_valid_q) || tx_drop_s) begin
            ovr_q <= 1'b1;
         end else if (cmd_wr_s && host_din[1]) begin
            ovr_q <= 1'b0;
         end
         // register select is latched at the start so the read completion acts on it
         if (rd_start_s) begin
            rd_a0_q <= host_a0;
         end
         host_dout_q <= host_a0 ? status_s : rx_reg_q;
      end
   end

`ifdef LINK_IRQ_EN
   logic [1:0] mask_q;
   logic       tx_done_q;
   logic       nint_q;

   assign irq_s     = (mask_q[1] & tx_done_q) | (mask_q[0] & rx_valid_q);
   assign nHOST_INT = nint_q;
   assign unused_s  = ^host_din[5:2];

   // Interrupt mask, write-done flag and interrupt pin
   always_ff @(posedge clk_16mhz or negedge nRESET) begin
      if (!nRESET) begin
         mask_q    <= 2'b00;
         tx_done_q <= 1'b0;
         nint_q    <= 1'b1;
      end else begin
         if (cmd_wr_s) begin
            mask_q <= host_din[7:6];
         end
         if (wr_done_s) begin
            tx_done_q <= 1'b1;
         end else if (rd_end_s && rd_a0_q) begin
            tx_done_q <= 1'b0;
         end
         nint_q <= ~irq_s;
      end
   end
`else
   assign irq_s     = 1'b0;
   assign nHOST_INT = 1'b1;
   assign unused_s  = ^{host_din[7:2], wr_done_s};
`endif

endmodule

// File: tb/tb_timex_host_link.sv
module tb_timex_host_link;

   localparam int SETUP  = 2;
   localparam int STROBE = 8;
   localparam int HOLD   = 2;

   logic       clk_16mhz = 1'b0;
   logic       nRESET    = 1'b0;
   logic       host_sel  = 1'b0;
   logic       host_a0   = 1'b0;
   logic       nRD       = 1'b1;
   logic       nWR       = 1'b1;
   logic [7:0] host_din  = 8'h00;
   logic [7:0] host_dout;
   logic       host_doe;
   wire  [7:0] ext_data;
   logic       nEXT_WR, nEXT_RD, nHOST_INT;

   logic [7:0] model_byte = 8'h00;

   // FDD board model: drives the bus only while nEXT_RD is low
   assign ext_data = (nEXT_RD == 1'b0) ? model_byte : 8'hzz;

   always #31 clk_16mhz = ~clk_16mhz;

   timex_host_link dut (
      .clk_16mhz (clk_16mhz),
      .nRESET    (nRESET),
      .host_sel  (host_sel),
      .host_a0   (host_a0),
      .nRD       (nRD),
      .nWR       (nWR),
      .host_din  (host_din),
      .host_dout (host_dout),
      .host_doe  (host_doe),
      .ext_data  (ext_data),
      .nEXT_WR   (nEXT_WR),
      .nEXT_RD   (nEXT_RD),
      .nHOST_INT (nHOST_INT)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_tx[$];
   logic [7:0] exp_rx[$];
   logic       ev_q[$];

   logic       mon_en   = 1'b0;
   logic       prev_wr  = 1'b1;
   logic       prev_rd  = 1'b1;
   int         wr_phase = 0;
   int         setup_cnt, low_cnt, hold_cnt, rd_low;
   logic       held_bad;
   logic [7:0] cur_byte;

   typedef struct {
      logic       fetch;
      logic [7:0] val;
      logic [7:0] exp_stat;
   } vec_t;
   vec_t vecs[6];

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic host_write(input logic a0, input logic [7:0] d);
      @(posedge clk_16mhz);
      #2;
      host_sel = 1'b1;
      host_a0  = a0;
      host_din = d;
      nWR      = 1'b0;
      repeat (4) @(posedge clk_16mhz);
      #2;
      nWR      = 1'b1;
      host_sel = 1'b0;
      @(posedge clk_16mhz);
   endtask

   task automatic host_read(input logic a0, output logic [7:0] d);
      @(posedge clk_16mhz);
      #2;
      host_sel = 1'b1;
      host_a0  = a0;
      nRD      = 1'b0;
      repeat (4) @(posedge clk_16mhz);
      #1;
      d = host_dout;
      check1("host_doe", host_doe, 1'b1);
      #1;
      nRD      = 1'b1;
      host_sel = 1'b0;
      @(posedge clk_16mhz);
   endtask

   task automatic read_check(input logic a0, input logic [7:0] exp, input string name);
      logic [7:0] d;
      host_read(a0, d);
      check8(name, d, exp);
   endtask

   // Link monitor body, sampled on the falling clock edge
   task automatic monitor_step();
      if (mon_en) begin
         if (prev_wr && !nEXT_WR) begin
            check1("wr_rd_overlap", nEXT_RD, 1'b1);
            ev_q.push_back(1'b0);
            if (exp_tx.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_wr: link byte %02h with none expected", ext_data);
               cur_byte = ext_data;
            end else begin
               cur_byte = exp_tx.pop_front();
               check8("wr_data", ext_data, cur_byte);
               check8("wr_setup", 8'(setup_cnt), 8'(SETUP));
            end
            low_cnt  = 1;
            held_bad = 1'b0;
            wr_phase = 1;
         end else if (wr_phase == 1) begin
            if (!nEXT_WR) begin
               low_cnt++;
               if (ext_data != cur_byte) held_bad = 1'b1;
            end else begin
               check8("wr_strobe_width", 8'(low_cnt), 8'(STROBE));
               check1("wr_data_held", held_bad, 1'b0);
               hold_cnt = (ext_data == cur_byte) ? 1 : 0;
               wr_phase = 2;
            end
         end else if (wr_phase == 2) begin
            if (nEXT_WR && ext_data == cur_byte) begin
               hold_cnt++;
            end else begin
               check8("wr_hold", 8'(hold_cnt), 8'(HOLD));
               wr_phase  = 0;
               setup_cnt = 0;
            end
         end else begin
            if (nEXT_WR && exp_tx.size() > 0 && ext_data == exp_tx[0]) setup_cnt++;
            else setup_cnt = 0;
         end
         if (prev_rd && !nEXT_RD) begin
            check1("rd_wr_overlap", nEXT_WR, 1'b1);
            ev_q.push_back(1'b1);
            rd_low = 1;
         end else if (!nEXT_RD) begin
            rd_low++;
         end else if (!prev_rd) begin
            check8("rd_strobe_width", 8'(rd_low), 8'(STROBE));
         end
      end
      prev_wr = nEXT_WR;
      prev_rd = nEXT_RD;
   endtask

   initial begin
      logic [7:0] d;
      int lat;

      vecs[0] = '{1'b0, 8'hA5, 8'h00};
      vecs[1] = '{1'b0, 8'h5A, 8'h00};
      vecs[2] = '{1'b0, 8'hFF, 8'h00};
      vecs[3] = '{1'b1, 8'h3C, 8'h40};
      vecs[4] = '{1'b1, 8'hC3, 8'h40};
      vecs[5] = '{1'b0, 8'h01, 8'h00};

      fork
         forever begin
            @(negedge clk_16mhz);
            monitor_step();
         end
      join_none

      // Reset state
      repeat (3) @(posedge clk_16mhz);
      #2 nRESET = 1'b1;
      @(negedge clk_16mhz);
      check1("rst_nEXT_WR", nEXT_WR, 1'b1);
      check1("rst_nEXT_RD", nEXT_RD, 1'b1);
      check1("rst_nHOST_INT", nHOST_INT, 1'b1);
      check1("rst_host_doe", host_doe, 1'b0);
      read_check(1'b1, 8'h00, "rst_status");

      // Reset in the middle of a write strobe
      host_write(1'b0, 8'hA5);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (nEXT_WR == 1'b0) begin
            lat = 1;
            break;
         end
         @(posedge clk_16mhz);
      end
      check1("rst_test_strobe_seen", lat[0], 1'b1);
      repeat (3) @(posedge clk_16mhz);
      #3 nRESET = 1'b0;
      #1;
      check1("midrst_nEXT_WR", nEXT_WR, 1'b1);
      check1("midrst_ext_released", ext_data == 8'hA5, 1'b0);
      repeat (2) @(posedge clk_16mhz);
      #2 nRESET = 1'b1;
      repeat (2) @(posedge clk_16mhz);
      read_check(1'b1, 8'h00, "midrst_status");
      wr_phase  = 0;
      setup_cnt = 0;
      mon_en    = 1'b1;

      // Write latency and busy status during the cycle
      exp_tx.push_back(8'hA5);
      @(posedge clk_16mhz);
      #2;
      host_sel = 1'b1;
      host_a0  = 1'b0;
      host_din = 8'hA5;
      nWR      = 1'b0;
      lat      = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk_16mhz);
         #1;
         if (i == 4) begin
            nWR      = 1'b1;
            host_sel = 1'b0;
         end
         if (nEXT_WR == 1'b0) begin
            lat = i;
            break;
         end
      end
      nWR      = 1'b1;
      host_sel = 1'b0;
      check8("wr_latency", 8'(lat), 8'(3 + SETUP));
      read_check(1'b1, 8'h80, "status_tx_busy");
      repeat (20) @(posedge clk_16mhz);
      read_check(1'b1, 8'h00, "status_after_wr");

      // Table of writes and fetches
      for (int v = 0; v < 6; v++) begin
         if (vecs[v].fetch) begin
            model_byte = vecs[v].val;
            exp_rx.push_back(vecs[v].val);
            host_write(1'b1, 8'h01);
         end else begin
            exp_tx.push_back(vecs[v].val);
            host_write(1'b0, vecs[v].val);
         end
         repeat (25) @(posedge clk_16mhz);
         read_check(1'b1, vecs[v].exp_stat, "vec_status");
         if (vecs[v].fetch) begin
            read_check(1'b0, exp_rx.pop_front(), "vec_rx_data");
            read_check(1'b1, 8'h00, "vec_status_after_read");
         end
      end

      // Write while busy is dropped and flagged
      exp_tx.push_back(8'h11);
      host_write(1'b0, 8'h11);
      host_write(1'b0, 8'h22);
      repeat (25) @(posedge clk_16mhz);
      read_check(1'b1, 8'h10, "tx_ovr_status");
      host_write(1'b1, 8'h02);
      read_check(1'b1, 8'h00, "tx_ovr_cleared");

      // Second capture before the host read overwrites and flags
      model_byte = 8'h21;
      host_write(1'b1, 8'h01);
      repeat (25) @(posedge clk_16mhz);
      model_byte = 8'h42;
      exp_rx.push_back(8'h42);
      host_write(1'b1, 8'h01);
      repeat (25) @(posedge clk_16mhz);
      read_check(1'b1, 8'h50, "rx_ovr_status");
      read_check(1'b0, exp_rx.pop_front(), "rx_ovr_data");
      read_check(1'b1, 8'h10, "rx_ovr_after_read");
      host_write(1'b1, 8'h02);
      read_check(1'b1, 8'h00, "rx_ovr_cleared");

      // Write and fetch back to back: write cycle first, then the read cycle
      ev_q.delete();
      model_byte = 8'h66;
      exp_tx.push_back(8'h55);
      exp_rx.push_back(8'h66);
      host_write(1'b0, 8'h55);
      host_write(1'b1, 8'h01);
      repeat (40) @(posedge clk_16mhz);
      check8("order_count", 8'(ev_q.size()), 8'd2);
      if (ev_q.size() == 2) begin
         check1("order_first_wr", ev_q[0], 1'b0);
         check1("order_second_rd", ev_q[1], 1'b1);
      end
      read_check(1'b0, exp_rx.pop_front(), "order_rx_data");
      read_check(1'b1, 8'h00, "order_status");

      // Interrupt on capture
      model_byte = 8'h99;
      exp_rx.push_back(8'h99);
      host_write(1'b1, 8'h41);
      repeat (25) @(posedge clk_16mhz);
`ifdef LINK_IRQ_EN
      check1("irq_asserted", nHOST_INT, 1'b0);
      read_check(1'b1, 8'h48, "irq_status");
`else
      check1("irq_tied_high", nHOST_INT, 1'b1);
      read_check(1'b1, 8'h40, "irq_status");
`endif
      read_check(1'b0, exp_rx.pop_front(), "irq_rx_data");
      repeat (5) @(posedge clk_16mhz);
      #1;
      check1("irq_released", nHOST_INT, 1'b1);

      check8("tx_scoreboard_empty", 8'(exp_tx.size()), 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
